// File: rtl/sum_accumulator.sv
// sum_accumulator
//   Registered adder/accumulator with a valid/ready handshake. Each accepted
//   beat either adds two operands (SUM) or updates one of CHANNELS
//   independent accumulators: wrapping add, saturating add, or read-and-clear.
//   The result of every beat is presented one cycle later in a single output
//   register stage that honours backpressure.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   ena        block enable; low freezes every register
//   in_valid   operand beat valid
//   in_ready   block can accept a beat (combinational)
//   op_a       operand A / accumulate addend
//   op_b       operand B, used in SUM mode only
//   ch_sel     target accumulator
//   mode       00 SUM, 01 ACC, 10 SAT_ACC, 11 CLEAR
//   out_valid  result register holds a valid beat
//   out_ready  consumer accepts the result
//   result     registered result
//   carry      carry-out of the addition that produced result
//   sat        saturation occurred on this result
//   out_ch     channel of this result (0 in SUM mode)
module sum_accumulator #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = $clog2(CHANNELS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [CH_BITS-1:0] ch_sel,
    input  logic [1:0]         mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               sat,
    output logic [CH_BITS-1:0] out_ch
);

    localparam logic [1:0] MODE_SUM   = 2'b00;
    localparam logic [1:0] MODE_ACC   = 2'b01;
    localparam logic [1:0] MODE_SAT   = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    // Unsigned add with the carry kept as the top bit.
    function automatic logic [WIDTH:0] add_with_carry(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic [WIDTH-1:0]   acc_r [CHANNELS];
    logic               out_valid_r;
    logic [WIDTH-1:0]   result_r;
    logic               carry_r;
    logic               sat_r;
    logic [CH_BITS-1:0] out_ch_r;

    logic               in_ready_s;
    logic               accept_s;
    logic [WIDTH-1:0]   acc_sel_s;
    logic [WIDTH:0]     add_s;
    logic [WIDTH-1:0]   nxt_res_s;
    logic               nxt_carry_s;
    logic               nxt_sat_s;
    logic [CH_BITS-1:0] nxt_ch_s;
    logic               acc_we_s;
    logic [WIDTH-1:0]   nxt_acc_s;

    // Handshake: a full output register may be refilled in the same cycle it drains.
    always_comb begin
        in_ready_s = ena & (~out_valid_r | out_ready);
        accept_s   = in_valid & in_ready_s;
    end

    // Datapath for the beat currently offered on the inputs.
    always_comb begin
        acc_sel_s   = acc_r[ch_sel];
        add_s       = {(WIDTH+1){1'b0}};
        nxt_res_s   = {WIDTH{1'b0}};
        nxt_carry_s = 1'b0;
        nxt_sat_s   = 1'b0;
        nxt_ch_s    = {CH_BITS{1'b0}};
        acc_we_s    = 1'b0;
        nxt_acc_s   = {WIDTH{1'b0}};
        case (mode)
            MODE_SUM: begin
                add_s       = add_with_carry(op_a, op_b);
                nxt_res_s   = add_s[WIDTH-1:0];
                nxt_carry_s = add_s[WIDTH];
            end
            MODE_ACC: begin
                add_s       = add_with_carry(acc_sel_s, op_a);
                nxt_res_s   = add_s[WIDTH-1:0];
                nxt_carry_s = add_s[WIDTH];
                nxt_ch_s    = ch_sel;
                acc_we_s    = 1'b1;
                nxt_acc_s   = add_s[WIDTH-1:0];
            end
            MODE_SAT: begin
                add_s       = add_with_carry(acc_sel_s, op_a);
                nxt_carry_s = add_s[WIDTH];
                nxt_ch_s    = ch_sel;
                acc_we_s    = 1'b1;
                if (add_s[WIDTH]) begin
                    // Overflow clamps both the accumulator and the result to all-ones.
                    nxt_res_s = {WIDTH{1'b1}};
                    nxt_sat_s = 1'b1;
                end else begin
                    nxt_res_s = add_s[WIDTH-1:0];
                    nxt_sat_s = 1'b0;
                end
                nxt_acc_s   = nxt_res_s;
            end
            MODE_CLEAR: begin
                // Report the old value, then zero the channel.
                nxt_res_s = acc_sel_s;
                nxt_ch_s  = ch_sel;
                acc_we_s  = 1'b1;
                nxt_acc_s = {WIDTH{1'b0}};
            end
            default: begin
                nxt_res_s = {WIDTH{1'b0}};
            end
        endcase
    end

    // Accumulator bank: only the selected channel is written, and only on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_r[i] <= {WIDTH{1'b0}};
            end
        end else if (accept_s && acc_we_s) begin
            acc_r[ch_sel] <= nxt_acc_s;
        end
    end

    // Output register stage: load on accept, drop valid on drain, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            carry_r     <= 1'b0;
            sat_r       <= 1'b0;
            out_ch_r    <= {CH_BITS{1'b0}};
        end else if (ena) begin
            if (accept_s) begin
                out_valid_r <= 1'b1;
                result_r    <= nxt_res_s;
                carry_r     <= nxt_carry_s;
                sat_r       <= nxt_sat_s;
                out_ch_r    <= nxt_ch_s;
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign carry     = carry_r;
    assign sat       = sat_r;
    assign out_ch    = out_ch_r;

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator
//   Self-checking bench for sum_accumulator. The default 8-bit/4-channel
//   instance is driven one cycle at a time; a bench-side model predicts
//   in_ready, out_valid and the result of every accepted beat, pushing the
//   prediction into a queue that is popped when the result register loads.
//   A second 16-bit/8-channel instance covers the wider parameter set.
module tb_sum_accumulator;

    localparam logic [1:0] M_SUM = 2'd0;
    localparam logic [1:0] M_ACC = 2'd1;
    localparam logic [1:0] M_SAT = 2'd2;
    localparam logic [1:0] M_CLR = 2'd3;

    typedef struct packed {
        logic [7:0] res;
        logic       carry;
        logic       sat;
        logic [1:0] ch;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, ena, in_valid, out_ready;
    logic [7:0] op_a, op_b;
    logic [1:0] ch_sel, mode;
    logic       in_ready, out_valid, carry, sat;
    logic [7:0] result;
    logic [1:0] out_ch;

    logic        w_ena, w_valid, w_ordy, w_ready, w_ovalid, w_carry, w_sat;
    logic [15:0] w_a, w_b, w_res;
    logic [2:0]  w_ch, w_och;
    logic [1:0]  w_mode;

    exp_t       exp_q[$];
    exp_t       last_exp;
    logic [7:0] mdl_acc [4];
    logic       mdl_valid;
    int         total = 0;
    int         bad   = 0;

    always #5 clk = ~clk;

    sum_accumulator u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .ch_sel(ch_sel), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry(carry), .sat(sat), .out_ch(out_ch)
    );

    sum_accumulator #(.WIDTH(16), .CHANNELS(8)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .ena(w_ena), .in_valid(w_valid), .in_ready(w_ready),
        .op_a(w_a), .op_b(w_b), .ch_sel(w_ch), .mode(w_mode),
        .out_valid(w_ovalid), .out_ready(w_ordy), .result(w_res),
        .carry(w_carry), .sat(w_sat), .out_ch(w_och)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mdl_acc[i] = 8'd0;
        mdl_valid = 1'b0;
        exp_q.delete();
        last_exp = '0;
    endtask

    // One clock cycle with the inputs as currently driven; starts and ends just after a negedge.
    task automatic step(input string tag);
        logic       exp_ready;
        logic       acc;
        logic [8:0] s;
        exp_t       e;
        #1;
        exp_ready = ena & (~mdl_valid | out_ready);
        check_val({tag, "/in_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
        acc = in_valid & exp_ready;
        if (acc) begin
            e = '0;
            e.ch = (mode == M_SUM) ? 2'd0 : ch_sel;
            case (mode)
                M_SUM: begin
                    s = {1'b0, op_a} + {1'b0, op_b};
                    e.res = s[7:0]; e.carry = s[8];
                end
                M_ACC: begin
                    s = {1'b0, mdl_acc[ch_sel]} + {1'b0, op_a};
                    e.res = s[7:0]; e.carry = s[8];
                    mdl_acc[ch_sel] = s[7:0];
                end
                M_SAT: begin
                    s = {1'b0, mdl_acc[ch_sel]} + {1'b0, op_a};
                    e.carry = s[8];
                    e.sat   = s[8];
                    e.res   = (s > 9'd255) ? 8'd255 : s[7:0];
                    mdl_acc[ch_sel] = e.res;
                end
                default: begin
                    e.res = mdl_acc[ch_sel];
                    mdl_acc[ch_sel] = 8'd0;
                end
            endcase
            exp_q.push_back(e);
        end
        if (ena) begin
            if (acc) mdl_valid = 1'b1;
            else if (out_ready) mdl_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_val({tag, "/out_valid"}, {31'd0, out_valid}, {31'd0, mdl_valid});
        if (acc) begin
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s/queue: got=empty expected=entry", tag);
            end else begin
                last_exp = exp_q.pop_front();
            end
        end
        if (mdl_valid) begin
            check_val({tag, "/result"}, {24'd0, result}, {24'd0, last_exp.res});
            check_val({tag, "/carry"},  {31'd0, carry},  {31'd0, last_exp.carry});
            check_val({tag, "/sat"},    {31'd0, sat},    {31'd0, last_exp.sat});
            check_val({tag, "/out_ch"}, {30'd0, out_ch}, {30'd0, last_exp.ch});
        end
        @(negedge clk);
    endtask

    task automatic beat(input string tag, input logic [1:0] m, input logic [1:0] ch,
                        input logic [7:0] a, input logic [7:0] b);
        in_valid = 1'b1; mode = m; ch_sel = ch; op_a = a; op_b = b;
        step(tag);
    endtask

    task automatic idle(input string tag);
        in_valid = 1'b0;
        step(tag);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "/out_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "/result"},    {24'd0, result},    32'd0);
        check_val({tag, "/carry"},     {31'd0, carry},     32'd0);
        check_val({tag, "/sat"},       {31'd0, sat},       32'd0);
        check_val({tag, "/out_ch"},    {30'd0, out_ch},    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s16;
        rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_a = 8'd0; op_b = 8'd0; ch_sel = 2'd0; mode = M_SUM;
        w_ena = 1'b1; w_valid = 1'b0; w_ordy = 1'b1;
        w_a = 16'd0; w_b = 16'd0; w_ch = 3'd0; w_mode = M_SUM;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Plain sum with carry, then every accumulator reads 0.
        beat("sum", M_SUM, 2'd0, 8'd200, 8'd100);
        for (int c = 0; c < 4; c++) beat($sformatf("clr_init%0d", c), M_CLR, c[1:0], 8'd0, 8'd0);
        idle("idle0");

        // Back-to-back accumulate on ch1, then read-and-clear twice.
        beat("acc1_a", M_ACC, 2'd1, 8'd10, 8'd99);
        beat("acc1_b", M_ACC, 2'd1, 8'd20, 8'd99);
        beat("clr1_a", M_CLR, 2'd1, 8'd0, 8'd0);
        beat("clr1_b", M_CLR, 2'd1, 8'd0, 8'd0);
        beat("clr0",   M_CLR, 2'd0, 8'd0, 8'd0);
        beat("clr2",   M_CLR, 2'd2, 8'd0, 8'd0);
        beat("clr3",   M_CLR, 2'd3, 8'd0, 8'd0);

        // Saturating vs wrapping overflow.
        beat("sat2_a", M_SAT, 2'd2, 8'd250, 8'd0);
        beat("sat2_b", M_SAT, 2'd2, 8'd10,  8'd0);
        beat("acc3_a", M_ACC, 2'd3, 8'd250, 8'd0);
        beat("acc3_b", M_ACC, 2'd3, 8'd10,  8'd0);
        idle("idle1");

        // Backpressure: one beat lands, the next waits until out_ready returns.
        out_ready = 1'b0;
        beat("bp_first", M_ACC, 2'd0, 8'd5, 8'd0);
        for (int i = 0; i < 3; i++) step($sformatf("bp_hold%0d", i));
        out_ready = 1'b1;
        step("bp_release");
        idle("bp_drain");
        beat("bp_clr0", M_CLR, 2'd0, 8'd0, 8'd0);

        // Enable low: nothing accepted, nothing drained, outputs frozen.
        beat("ena_pre", M_ACC, 2'd1, 8'd7, 8'd0);
        ena = 1'b0;
        in_valid = 1'b1; mode = M_ACC; ch_sel = 2'd1; op_a = 8'd3;
        for (int i = 0; i < 4; i++) step($sformatf("ena_off%0d", i));
        ena = 1'b1;
        step("ena_on");
        idle("ena_drain");

        // Asynchronous reset in the middle of a burst.
        beat("burst_a", M_ACC, 2'd2, 8'd1, 8'd0);
        beat("burst_b", M_ACC, 2'd3, 8'd1, 8'd0);
        in_valid = 1'b1; mode = M_ACC; ch_sel = 2'd3; op_a = 8'd9;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_reset();
        @(negedge clk);
        check_zero_outputs("rst_held");
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) beat($sformatf("clr_post%0d", c), M_CLR, c[1:0], 8'd0, 8'd0);
        idle("idle2");

        // Wide instance: saturating accumulate on the top channel.
        w_valid = 1'b1; w_mode = M_SAT; w_ch = 3'd7; w_a = 16'd65000; w_b = 16'd0;
        #1;
        check_val("w16/in_ready", {31'd0, w_ready}, 32'd1);
        @(posedge clk); #1;
        check_val("w16_a/result", {16'd0, w_res}, 32'd65000);
        check_val("w16_a/sat",    {31'd0, w_sat}, 32'd0);
        @(negedge clk);
        w_a = 16'd1000;
        @(posedge clk); #1;
        s16 = 65000 + 1000;
        if (s16 > 65535) s16 = 65535;
        check_val("w16_b/out_valid", {31'd0, w_ovalid}, 32'd1);
        check_val("w16_b/result",    {16'd0, w_res},    s16);
        check_val("w16_b/sat",       {31'd0, w_sat},    32'd1);
        check_val("w16_b/carry",     {31'd0, w_carry},  32'd1);
        check_val("w16_b/out_ch",    {29'd0, w_och},    32'd7);
        @(negedge clk);
        w_valid = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Parametrised, registered successor to the combinational 8-bit demo adder.
- Operates on operand pairs over a valid/ready handshake. Supports plain sum, per-channel wrap accumulate, per-channel saturating accumulate, and read-and-clear.
- Holds CHANNELS independent accumulators. Drives one registered result stage with backpressure.
- Instantiated under a tt_um_* top; ui_in/uio_in map onto operands, uo_out maps onto result.

Parameters:
- WIDTH, 8, operand/accumulator/result width in bits (>=2).
- CHANNELS, 4, number of accumulators (power of two, >=2).
- CH_BITS, $clog2(CHANNELS), channel index width (derived; do not override).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  block enable; low freezes all state.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat.
- op_a  input  WIDTH  operand A / accumulate addend.
- op_b  input  WIDTH  operand B (SUM mode only).
- ch_sel  input  CH_BITS  target accumulator.
- mode  input  2  00 SUM, 01 ACC, 10 SAT_ACC, 11 CLEAR.
- out_valid  output  1  result register valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- carry  output  1  carry-out of the addition producing result.
- sat  output  1  saturation occurred on this result.
- out_ch  output  CH_BITS  channel of this result (0 in SUM mode).

Behaviour:
- Reset (async assert, sync release): all accumulators 0; out_valid, result, carry, sat, out_ch all 0. Takes effect mid-transfer; any in-flight beat is discarded.
- in_ready = ena & (~out_valid | out_ready). This is combinational, so there is no bubble under continuous flow.
- Accept = in_valid & in_ready. Latency is 1 cycle: the accepted beat appears with out_valid=1 on the next edge.
- Backpressure: while out_valid & ~out_ready, result, carry, sat and out_ch hold stable. No accept occurs and no accumulator changes.
- out_valid clears on out_ready & ~accept. It stays 1 on simultaneous drain and accept, with the new data loaded.
- SUM: {carry,result} = op_a + op_b in WIDTH+1 bits, with wrap. Accumulators are untouched. sat=0. out_ch=0.
- ACC: {carry,nxt} = acc[ch_sel] + op_a. acc[ch_sel] and result both take nxt, which wraps modulo 2^WIDTH. sat=0.
- SAT_ACC: same sum. If the carry is set, acc and result become 2^WIDTH-1 with sat=1 and carry=1; otherwise the behaviour matches ACC.
- CLEAR: result = acc[ch_sel] (old value), then acc[ch_sel] <= 0. carry=0, sat=0.
- Accumulator update happens on the accept edge. A back-to-back beat to the same channel sees the updated value, so no hazard or forwarding is needed.
- Only the selected channel changes. Other channels hold.
- ena low: in_ready=0 and all registers hold, including out_valid. out_valid/result stay visible, but no drain occurs.
- op_b is ignored outside SUM mode. in_valid with ena low is not accepted; the source must hold the beat.
- All arithmetic is unsigned.

Test Plan:
- Reset, then SUM with a=200, b=100, out_ready=1 -> next cycle out_valid=1, result=44, carry=1, sat=0, out_ch=0. All accumulators read back 0 via CLEAR.
- ACC ch1 with a=10 then a=20 on consecutive cycles, out_ready=1 -> results 10, 30. CLEAR ch1 -> result 30. CLEAR ch1 again -> 0. ch0/2/3 stay 0.
- SAT_ACC ch2 with a=250 then a=10 -> results 250 (sat=0), then 255 (sat=1, carry=1). ACC ch3 with 250 then 10 -> 250, then 4 (carry=1, sat=0).
- Backpressure: out_ready=0 after one accepted beat, in_valid held with a=5 on ACC ch0 for 3 cycles -> in_ready=0 and result/acc0 unchanged. Raising out_ready -> beat accepted the same cycle, with no lost or duplicated beat.
- ena=0 for 4 cycles with in_valid=1 -> no accept and all outputs held. Async rst_n pulse mid-burst -> outputs and accumulators 0 immediately, before the next clock edge.
- Parameter sweep WIDTH=16, CHANNELS=8: SAT_ACC ch7 with 65000 + 1000 -> result 65535, sat=1, out_ch=7.
